// File: rtl/mc_control_fsm_if.sv
// Control-path bundle between the main control FSM and the RV32I datapath.
interface mc_control_fsm_if #(
   parameter int BUS_WIDTH = 32
);
   logic [BUS_WIDTH-1:0] inst;
   logic                 mem_ready;
   logic                 branch_taken;
   logic                 load_ir;
   logic                 pc_write;
   logic [1:0]           pc_src;
   logic                 mem_read;
   logic                 mem_write;
   logic                 iord;
   logic                 load_ab;
   logic                 alu_src_a;
   logic [1:0]           alu_src_b;
   logic [1:0]           alu_op;
   logic [1:0]           wb_sel;
   logic                 reg_write;
   logic                 illegal_inst;
   logic [2:0]           state;
   logic [BUS_WIDTH-1:0] instret;

   // Control FSM side
   modport slave (
      input  inst, mem_ready, branch_taken,
      output load_ir, pc_write, pc_src, mem_read, mem_write, iord, load_ab,
             alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, illegal_inst,
             state, instret
   );

   // Datapath side
   modport master (
      output inst, mem_ready, branch_taken,
      input  load_ir, pc_write, pc_src, mem_read, mem_write, iord, load_ab,
             alu_src_a, alu_src_b, alu_op, wb_sel, reg_write, illegal_inst,
             state, instret
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM for the RV32I core: fetch/decode/exec/mem/wb
// sequencing, strobe generation, illegal-opcode trap and retire counter.
module mc_control_fsm #(
   parameter int BUS_WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   mc_control_fsm_if.slave   bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t               state_q, state_d;
   logic                 illegal_q;
   logic [BUS_WIDTH-1:0] instret_q;

   logic [6:0] opcode;
   logic       is_load, is_jump, known_op, retire;
   logic       load_ir, pc_write, mem_read, mem_write, iord, load_ab;
   logic       alu_src_a, reg_write;
   logic [1:0] pc_src, alu_src_b, alu_op, wb_sel;

   assign opcode   = bus.inst[6:0];
   assign is_load  = (opcode == OP_LOAD);
   assign is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
   assign known_op = (opcode == OP_R)      || (opcode == OP_IALU)  ||
                     (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                     (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
                     (opcode == OP_JALR)   || (opcode == OP_LUI)   ||
                     (opcode == OP_AUIPC);

   // Next-state and strobe decode; reset gates every strobe and the retire pulse
   always_comb begin
      state_d   = state_q;
      retire    = 1'b0;
      load_ir   = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      load_ab   = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      alu_op    = 2'd0;
      wb_sel    = 2'd0;
      reg_write = 1'b0;
      case (state_q)
         FETCH: begin
            mem_read = 1'b1;
            if (bus.mem_ready) begin
               load_ir  = 1'b1;
               pc_write = 1'b1;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            load_ab = 1'b1;
            state_d = known_op ? EXEC : TRAP;
         end
         EXEC: begin
            case (opcode)
               OP_R: begin
                  alu_op  = 2'd1;
                  state_d = WB;
               end
               OP_IALU: begin
                  alu_op    = 2'd1;
                  alu_src_b = 2'd1;
                  state_d   = WB;
               end
               OP_LUI: begin
                  alu_op    = 2'd2;
                  alu_src_b = 2'd1;
                  state_d   = WB;
               end
               OP_AUIPC: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'd1;
                  state_d   = WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_b = 2'd1;
                  state_d   = MEM;
               end
               OP_BRANCH: begin
                  pc_write  = bus.branch_taken;
                  pc_src    = 2'd1;
                  alu_src_a = 1'b1;
                  alu_src_b = 2'd1;
                  state_d   = FETCH;
                  retire    = 1'b1;
               end
               OP_JAL, OP_JALR: begin
                  alu_src_a = (opcode == OP_JAL);
                  alu_src_b = 2'd1;
                  pc_write  = 1'b1;
                  pc_src    = 2'd1;
                  state_d   = WB;
               end
               default: state_d = TRAP;
            endcase
         end
         MEM: begin
            iord      = 1'b1;
            mem_read  = is_load;
            mem_write = !is_load;
            if (bus.mem_ready) begin
               if (is_load) begin
                  state_d = WB;
               end else begin
                  state_d = FETCH;
                  retire  = 1'b1;
               end
            end
         end
         WB: begin
            reg_write = (bus.inst[11:7] != 5'd0);
            wb_sel    = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
            state_d   = FETCH;
            retire    = 1'b1;
         end
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
      if (rst) begin
         retire    = 1'b0;
         load_ir   = 1'b0;
         pc_write  = 1'b0;
         pc_src    = 2'd0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         iord      = 1'b0;
         load_ab   = 1'b0;
         alu_src_a = 1'b0;
         alu_src_b = 2'd0;
         alu_op    = 2'd0;
         wb_sel    = 2'd0;
         reg_write = 1'b0;
      end
   end

   // State register, sticky trap flag and wrapping retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == TRAP) illegal_q <= 1'b1;
         if (retire)          instret_q <= instret_q + 1'b1;
      end
   end

   assign bus.load_ir      = load_ir;
   assign bus.pc_write     = pc_write;
   assign bus.pc_src       = pc_src;
   assign bus.mem_read     = mem_read;
   assign bus.mem_write    = mem_write;
   assign bus.iord         = iord;
   assign bus.load_ab      = load_ab;
   assign bus.alu_src_a    = alu_src_a;
   assign bus.alu_src_b    = alu_src_b;
   assign bus.alu_op       = alu_op;
   assign bus.wb_sel       = wb_sel;
   assign bus.reg_write    = reg_write;
   assign bus.illegal_inst = illegal_q;
   assign bus.state        = state_q;
   assign bus.instret      = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: instruction sequences with hand-computed
// state walks and strobe values.
module tb_mc_control_fsm;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   mc_control_fsm_if #(.BUS_WIDTH(32)) bus ();

   mc_control_fsm #(.BUS_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst              = 1'b1;
      bus.inst         = 32'h0;
      bus.mem_ready    = 1'b0;
      bus.branch_taken = 1'b0;

      // reset
      tick();
      chk("rst_state", {29'd0, bus.state}, 0);
      chk("rst_instret", bus.instret, 0);
      chk("rst_illegal", {31'd0, bus.illegal_inst}, 0);
      chk("rst_mem_read_gated", {31'd0, bus.mem_read}, 0);
      chk("rst_load_ir_gated", {31'd0, bus.load_ir}, 0);

      // add x3,x1,x2 : 0,1,2,4,0
      rst = 1'b0; bus.inst = 32'h002081B3; bus.mem_ready = 1'b1; #1;
      chk("add_f_state", {29'd0, bus.state}, 0);
      chk("add_f_mem_read", {31'd0, bus.mem_read}, 1);
      chk("add_f_iord", {31'd0, bus.iord}, 0);
      chk("add_f_load_ir", {31'd0, bus.load_ir}, 1);
      chk("add_f_pc_write", {31'd0, bus.pc_write}, 1);
      chk("add_f_pc_src", {30'd0, bus.pc_src}, 0);
      tick();
      chk("add_d_state", {29'd0, bus.state}, 1);
      chk("add_d_load_ab", {31'd0, bus.load_ab}, 1);
      chk("add_d_load_ir", {31'd0, bus.load_ir}, 0);
      tick();
      chk("add_e_state", {29'd0, bus.state}, 2);
      chk("add_e_alu_op", {30'd0, bus.alu_op}, 1);
      chk("add_e_alu_src_b", {30'd0, bus.alu_src_b}, 0);
      tick();
      chk("add_w_state", {29'd0, bus.state}, 4);
      chk("add_w_reg_write", {31'd0, bus.reg_write}, 1);
      chk("add_w_wb_sel", {30'd0, bus.wb_sel}, 0);
      tick();
      chk("add_ret_state", {29'd0, bus.state}, 0);
      chk("add_instret", bus.instret, 1);

      // lw x5,4(x1) with two MEM wait cycles
      bus.inst = 32'h0040A283; #1;
      chk("lw_f_load_ir", {31'd0, bus.load_ir}, 1);
      tick();
      chk("lw_d_state", {29'd0, bus.state}, 1);
      tick();
      chk("lw_e_state", {29'd0, bus.state}, 2);
      chk("lw_e_alu_src_b", {30'd0, bus.alu_src_b}, 1);
      chk("lw_e_alu_op", {30'd0, bus.alu_op}, 0);
      bus.mem_ready = 1'b0;
      tick();
      chk("lw_m1_state", {29'd0, bus.state}, 3);
      chk("lw_m1_mem_read", {31'd0, bus.mem_read}, 1);
      chk("lw_m1_iord", {31'd0, bus.iord}, 1);
      chk("lw_m1_mem_write", {31'd0, bus.mem_write}, 0);
      tick();
      chk("lw_m2_state", {29'd0, bus.state}, 3);
      tick();
      chk("lw_m3_state", {29'd0, bus.state}, 3);
      chk("lw_m3_mem_read", {31'd0, bus.mem_read}, 1);
      bus.mem_ready = 1'b1;
      tick();
      chk("lw_w_state", {29'd0, bus.state}, 4);
      chk("lw_w_wb_sel", {30'd0, bus.wb_sel}, 1);
      chk("lw_w_reg_write", {31'd0, bus.reg_write}, 1);
      chk("lw_w_instret", bus.instret, 1);
      tick();
      chk("lw_ret_state", {29'd0, bus.state}, 0);
      chk("lw_instret", bus.instret, 2);

      // beq not taken, then taken
      bus.inst = 32'h00208463; bus.branch_taken = 1'b0;
      tick(); tick(); #1;
      chk("beq0_e_state", {29'd0, bus.state}, 2);
      chk("beq0_e_pc_write", {31'd0, bus.pc_write}, 0);
      chk("beq0_e_alu_src_a", {31'd0, bus.alu_src_a}, 1);
      tick();
      chk("beq0_ret_state", {29'd0, bus.state}, 0);
      chk("beq0_instret", bus.instret, 3);
      tick(); tick();
      bus.branch_taken = 1'b1; #1;
      chk("beq1_e_pc_write", {31'd0, bus.pc_write}, 1);
      chk("beq1_e_pc_src", {30'd0, bus.pc_src}, 1);
      tick();
      chk("beq1_ret_state", {29'd0, bus.state}, 0);
      chk("beq1_instret", bus.instret, 4);
      bus.branch_taken = 1'b0;

      // addi x0,x0,1 : no register write
      bus.inst = 32'h00100013;
      tick(); tick();
      chk("addi_e_alu_op", {30'd0, bus.alu_op}, 1);
      chk("addi_e_alu_src_b", {30'd0, bus.alu_src_b}, 1);
      tick();
      chk("addi_w_state", {29'd0, bus.state}, 4);
      chk("addi_w_reg_write", {31'd0, bus.reg_write}, 0);
      tick();
      chk("addi_instret", bus.instret, 5);

      // jal x1,8 with one FETCH wait cycle
      bus.inst = 32'h008000EF; bus.mem_ready = 1'b0; #1;
      chk("jal_fw_load_ir", {31'd0, bus.load_ir}, 0);
      chk("jal_fw_mem_read", {31'd0, bus.mem_read}, 1);
      tick();
      chk("jal_fw_state", {29'd0, bus.state}, 0);
      bus.mem_ready = 1'b1;
      tick(); tick();
      chk("jal_e_pc_write", {31'd0, bus.pc_write}, 1);
      chk("jal_e_pc_src", {30'd0, bus.pc_src}, 1);
      chk("jal_e_alu_src_a", {31'd0, bus.alu_src_a}, 1);
      tick();
      chk("jal_w_wb_sel", {30'd0, bus.wb_sel}, 2);
      chk("jal_w_reg_write", {31'd0, bus.reg_write}, 1);
      tick();
      chk("jal_instret", bus.instret, 6);

      // lui x5,0x12345 with counter preloaded to all-ones: retire wraps
      bus.inst = 32'h123452B7;
      tick(); tick();
      chk("lui_e_alu_op", {30'd0, bus.alu_op}, 2);
      tick();
      chk("lui_w_state", {29'd0, bus.state}, 4);
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      #1;
      chk("wrap_pre", bus.instret, 32'hFFFF_FFFF);
      tick();
      chk("wrap_instret", bus.instret, 0);

      // sw x2,8(x1), reset asserted mid-MEM
      bus.inst = 32'h0020A423;
      tick(); tick();
      bus.mem_ready = 1'b0;
      tick();
      chk("sw_m_state", {29'd0, bus.state}, 3);
      chk("sw_m_mem_write", {31'd0, bus.mem_write}, 1);
      chk("sw_m_mem_read", {31'd0, bus.mem_read}, 0);
      rst = 1'b1; #1;
      chk("sw_rst_mem_write", {31'd0, bus.mem_write}, 0);
      chk("sw_rst_iord", {31'd0, bus.iord}, 0);
      tick();
      chk("sw_rst_state", {29'd0, bus.state}, 0);
      chk("sw_rst_instret", bus.instret, 0);
      rst = 1'b0; bus.mem_ready = 1'b1;

      // illegal opcode
      bus.inst = 32'h0000007F;
      tick();
      chk("ill_d_state", {29'd0, bus.state}, 1);
      tick();
      chk("ill_trap_state", {29'd0, bus.state}, 5);
      chk("ill_flag", {31'd0, bus.illegal_inst}, 1);
      chk("ill_mem_read", {31'd0, bus.mem_read}, 0);
      tick();
      chk("ill_stay_state", {29'd0, bus.state}, 5);
      chk("ill_instret", bus.instret, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0; #1;
      chk("ill_clr_state", {29'd0, bus.state}, 0);
      chk("ill_clr_flag", {31'd0, bus.illegal_inst}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle main control state machine for the RV32I core. Sequences every instruction through fetch, decode, execute, memory and write-back. Drives the instruction register's load strobe, the PC, memory, ALU-mux and register-file write controls. Decodes the opcode from the instruction register output and counts retired instructions.

## Interface
- `BUS_WIDTH`, 32: width of the instruction and the retire counter.
- `clk`  in  1: system clock. State updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `inst`  in  BUS_WIDTH: instruction register output (`inst_out`).
- `mem_ready`  in  1: memory has completed the current read or write this cycle.
- `branch_taken`  in  1: branch comparator result for the current instruction.
- `load_ir`  out  1: instruction register load strobe.
- `pc_write`  out  1: PC load strobe.
- `pc_src`  out  2: PC source. 0 = PC+4, 1 = ALU target.
- `mem_read`, `mem_write`  out  1 each: memory request strobes.
- `iord`  out  1: memory address select. 0 = PC, 1 = ALU result.
- `load_ab`  out  1: latch register-file operands A and B.
- `alu_src_a`  out  1: ALU A input. 0 = rs1, 1 = PC.
- `alu_src_b`  out  2: ALU B input. 0 = rs2, 1 = immediate, 2 = constant 4.
- `alu_op`  out  2: 0 = add, 1 = funct3/funct7 decoded, 2 = pass B.
- `wb_sel`  out  2: write-back data. 0 = ALU result, 1 = memory data, 2 = link (old PC+4).
- `reg_write`  out  1: register-file write enable.
- `illegal_inst`  out  1: sticky flag, set on an unknown opcode.
- `state`  out  3: current state (debug).
- `instret`  out  BUS_WIDTH: retired-instruction counter.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to FETCH on the next edge.
- Strobe outputs are combinational from `state`, `inst` and the inputs. They are stable before the falling edge, where the instruction register samples `load_ir`.
- Outputs not listed for a state are 0.
- FETCH:
  - `mem_read`=1, `iord`=0, held steady until `mem_ready`.
  - When `mem_ready`=1: `load_ir`=1 and `pc_write`=1 (`pc_src`=0), then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - `load_ab`=1.
  - Opcode `inst[6:0]` is one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111: go to EXEC.
  - Any other opcode: go to TRAP.
- EXEC, by instruction class:
  - R-type: `alu_op`=1, B=rs2. Go to WB.
  - I-ALU: `alu_op`=1, B=imm. Go to WB.
  - LUI: `alu_op`=2, B=imm. Go to WB.
  - AUIPC: A=PC, B=imm, add. Go to WB.
  - LOAD/STORE: add, B=imm. Go to MEM.
  - BRANCH: `pc_write`=`branch_taken`, `pc_src`=1, A=PC, B=imm. Go to FETCH and retire.
  - JAL: A=PC, B=imm. JALR: A=rs1, B=imm. Both: `pc_write`=1, `pc_src`=1, then go to WB.
- MEM:
  - `iord`=1. `mem_read`=1 for a load, `mem_write`=1 for a store. Hold until `mem_ready`.
  - Load with `mem_ready`: go to WB.
  - Store with `mem_ready`: go to FETCH and retire.
- WB:
  - `reg_write`=1 unless `inst[11:7]`==0.
  - `wb_sel`: 1 for a load, 2 for JAL/JALR, else 0.
  - Go to FETCH and retire.
- TRAP: all strobes 0, `illegal_inst`=1. Stays in TRAP until `rst`.
- `instret` increments by 1 on each retiring transition and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: while `rst`=1, all strobes are forced to 0 combinationally. On the next rising edge: `state`=FETCH, `instret`=0, `illegal_inst`=0.
- Reset in any state, including mid-MEM or mid-FETCH wait, abandons the instruction without retiring it.
- Latency with `mem_ready` already high: branch 3 cycles; R/I/LUI/AUIPC/JAL/JALR/store 4; load 5. Each wait cycle on `mem_ready` adds 1.
- If `mem_ready` is high outside FETCH/MEM, it is ignored.
- `load_ir` is asserted for exactly one cycle per fetched instruction.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with `mem_ready`=1: state sequence 0,1,2,4,0. `reg_write`=1 in WB. `instret`=1.
- `lw x5,4(x1)` (0x0040A283), `mem_ready` low 2 cycles in MEM: MEM lasts 3 cycles with `mem_read`=1, `iord`=1. WB has `wb_sel`=1. Total 7 cycles.
- `beq` with `branch_taken`=0, then `branch_taken`=1: first gives `pc_write`=0 in EXEC; second gives `pc_write`=1, `pc_src`=1. Each retires after 3 cycles.
- `addi x0,x0,1` (0x00100013): WB reached, `reg_write`=0.
- Opcode 0x0000007F: DECODE goes to TRAP, `illegal_inst`=1. `rst` pulse returns to FETCH with the flag cleared.
- Preload `instret` to 0xFFFFFFFF via 2^32 retires (or a forced value), retire one more: `instret`=0. Also assert `rst` mid-MEM: next state FETCH, no `mem_write` while `rst`=1.
